window_kernel_pairer: RTL and testbench

WINDOW_KERNEL_PAIRER -- requirements
Module: window_kernel_pairer

---
 rtl/window_kernel_pairer.sv | 151 +++++++++++++++
 tb/tb_window_kernel_pairer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/window_kernel_pairer.sv
// Streams an image through K_DIM-1 line buffers and a K_DIM x K_DIM shift window,
// pairing each complete window with a kernel loaded ahead of the image.
module window_kernel_pairer #(
  parameter int M_BITS    = 32,
  parameter int K_DIM     = 3,
  parameter int IMG_W_MAX = 16,
  parameter int I_BITS    = 8
) (
  input  logic                              clk,
  input  logic                              aresetn,
  input  logic [I_BITS-1:0]                 cfg_img_width,
  input  logic [K_DIM*M_BITS-1:0]           kernel_in_data,
  input  logic                              kernel_in_valid,
  input  logic                              kernel_in_last,
  output logic                              kernel_in_ready,
  input  logic [M_BITS-1:0]                 img_in_data,
  input  logic                              img_in_valid,
  input  logic                              img_in_last,
  output logic                              img_in_ready,
  output logic [K_DIM*K_DIM*M_BITS-1:0]     mult_data,
  output logic [K_DIM*K_DIM*M_BITS-1:0]     mult_kernel,
  output logic [2*I_BITS-1:0]               mult_user,
  output logic                              mult_valid,
  output logic                              mult_last,
  input  logic                              mult_ready,
  output logic                              err
);
  localparam int KW = $clog2(K_DIM + 1);
  localparam int CW = (IMG_W_MAX > 1) ? $clog2(IMG_W_MAX) : 1;

  typedef logic [K_DIM-1:0][K_DIM-1:0][M_BITS-1:0] win_t;
  typedef enum logic [1:0] {LOAD_KERNEL, STREAM, DRAIN} state_t;

  state_t                         state;
  logic [KW-1:0]                  krow;
  logic [I_BITS-1:0]              width, col, row;
  win_t                           kernel, win, nwin, out_data;
  logic [M_BITS-1:0]              lb [K_DIM-1][IMG_W_MAX];
  logic [K_DIM-1:0][M_BITS-1:0]   col_vec;
  logic [CW-1:0]                  cidx;
  logic                           kready, k_acc, p_acc, out_xfer;
  logic                           col_end, win_ok, k_done, w_lo, w_hi;

  assign kernel_in_ready = kready;
  assign img_in_ready    = (state == STREAM) && (!mult_valid || mult_ready);
  assign k_acc    = kernel_in_valid && kready && (state == LOAD_KERNEL);
  assign p_acc    = img_in_valid && img_in_ready;
  assign out_xfer = mult_valid && mult_ready;
  assign cidx     = col[CW-1:0];
  assign col_end  = (col == width - I_BITS'(1));
  assign win_ok   = (row >= I_BITS'(K_DIM-1)) && (col >= I_BITS'(K_DIM-1));
  assign k_done   = kernel_in_last || (krow == KW'(K_DIM-1));
  assign w_lo     = cfg_img_width < I_BITS'(K_DIM);
  assign w_hi     = cfg_img_width > I_BITS'(IMG_W_MAX);

  assign mult_data   = out_data;
  assign mult_kernel = kernel;

  // Column vector for the incoming pixel: oldest buffered row first, new pixel at the bottom.
  always_comb begin
    col_vec = '0;
    for (int r = 0; r < K_DIM-1; r++) col_vec[r] = lb[r][cidx];
    col_vec[K_DIM-1] = img_in_data;
    nwin = '0;
    for (int r = 0; r < K_DIM; r++) begin
      for (int c = 0; c < K_DIM-1; c++) nwin[r][c] = win[r][c+1];
      nwin[r][K_DIM-1] = col_vec[r];
    end
  end

  // Line buffers and window need no reset: every window is refilled before it is emitted.
  always_ff @(posedge clk) begin
    if (p_acc) begin
      for (int r = 0; r < K_DIM-2; r++) lb[r][cidx] <= lb[r+1][cidx];
      lb[K_DIM-2][cidx] <= img_in_data;
      win <= nwin;
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state      <= LOAD_KERNEL;
      kready     <= 1'b0;
      krow       <= '0;
      width      <= '0;
      col        <= '0;
      row        <= '0;
      kernel     <= '0;
      out_data   <= '0;
      mult_user  <= '0;
      mult_valid <= 1'b0;
      mult_last  <= 1'b0;
      err        <= 1'b0;
    end else begin
      err <= 1'b0;
      if (out_xfer) begin
        mult_valid <= 1'b0;
        mult_last  <= 1'b0;
      end
      case (state)
        LOAD_KERNEL: begin
          kready <= 1'b1;
          if (k_acc) begin
            // First beat clears stale rows so a short kernel leaves zeros behind.
            for (int r = 0; r < K_DIM; r++) begin
              if (KW'(r) == krow)  kernel[r] <= kernel_in_data;
              else if (krow == '0) kernel[r] <= '0;
            end
            krow <= krow + KW'(1);
            if (k_done) begin
              state  <= STREAM;
              kready <= 1'b0;
              krow   <= '0;
              col    <= '0;
              row    <= '0;
              width  <= w_lo ? I_BITS'(K_DIM) : (w_hi ? I_BITS'(IMG_W_MAX) : cfg_img_width);
              err    <= (kernel_in_last != (krow == KW'(K_DIM-1))) || w_lo || w_hi;
            end
          end
        end
        STREAM: begin
          if (p_acc) begin
            if (col_end) begin
              col <= '0;
              row <= row + I_BITS'(1);
            end else begin
              col <= col + I_BITS'(1);
            end
            if (win_ok) begin
              mult_valid <= 1'b1;
              out_data   <= nwin;
              mult_user  <= {row - I_BITS'(K_DIM-1), col - I_BITS'(K_DIM-1)};
              mult_last  <= img_in_last;
            end
            if (img_in_last) begin
              state <= DRAIN;
              err   <= !col_end || (row < I_BITS'(K_DIM-1));
            end
          end
        end
        DRAIN: begin
          if (!mult_valid || mult_ready) begin
            state  <= LOAD_KERNEL;
            kready <= 1'b1;
          end
        end
        default: state <= LOAD_KERNEL;
      endcase
    end
  end
endmodule

// File: tb/tb_window_kernel_pairer.sv
// Table-driven and randomized bench for window_kernel_pairer against a raster-order window model.
module tb_window_kernel_pairer;
  localparam int M  = 32;
  localparam int K  = 3;
  localparam int WM = 16;
  localparam int IB = 8;
  localparam int DW = K*K*M;

  logic            clk = 1'b0, aresetn = 1'b0;
  logic [IB-1:0]   cfg_img_width = '0;
  logic [K*M-1:0]  kernel_in_data = '0;
  logic            kernel_in_valid = 1'b0, kernel_in_last = 1'b0, kernel_in_ready;
  logic [M-1:0]    img_in_data = '0;
  logic            img_in_valid = 1'b0, img_in_last = 1'b0, img_in_ready;
  logic [DW-1:0]   mult_data, mult_kernel;
  logic [2*IB-1:0] mult_user;
  logic            mult_valid, mult_last, err;
  logic            mult_ready = 1'b1;

  window_kernel_pairer #(.M_BITS(M), .K_DIM(K), .IMG_W_MAX(WM), .I_BITS(IB)) dut (
    .clk(clk), .aresetn(aresetn), .cfg_img_width(cfg_img_width),
    .kernel_in_data(kernel_in_data), .kernel_in_valid(kernel_in_valid),
    .kernel_in_last(kernel_in_last), .kernel_in_ready(kernel_in_ready),
    .img_in_data(img_in_data), .img_in_valid(img_in_valid), .img_in_last(img_in_last),
    .img_in_ready(img_in_ready), .mult_data(mult_data), .mult_kernel(mult_kernel),
    .mult_user(mult_user), .mult_valid(mult_valid), .mult_last(mult_last),
    .mult_ready(mult_ready), .err(err));

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0, rmode = 0, err_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0]   d;
    logic [DW-1:0]   k;
    logic [2*IB-1:0] u;
    logic            l;
    int              c;
  } obs_t;
  obs_t got[$];

  typedef struct {
    int nk, klast, cfg, npix, rmode;
    bit rpix;
    int exp_nwin, exp_err, exp_lu;
  } vec_t;
  vec_t tbl[10];

  logic [M-1:0] pix [64];
  int           acc_cyc [64];

  task automatic chk(string n, longint a, longint e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic chkw(string n, logic [DW-1:0] a, logic [DW-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       mult_ready = 1'b1;
      1:       mult_ready = (cyc % 8) >= 2;
      default: mult_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Transfer capture plus stall-hold checks, sampled mid-cycle.
  logic            hold = 1'b0, hl;
  logic [DW-1:0]   hd;
  logic [2*IB-1:0] hu;
  always @(negedge clk) begin
    obs_t o;
    if (!aresetn) hold = 1'b0;
    else begin
      if (err) err_cnt++;
      if (hold) begin
        chk("stall_valid", longint'(mult_valid), 1);
        chkw("stall_data", mult_data, hd);
        chk("stall_user_last", {mult_user, mult_last}, {hu, hl});
      end
      if (mult_valid && !mult_ready) chk("stall_img_ready", longint'(img_in_ready), 0);
      if (mult_valid && mult_ready) begin
        o.d = mult_data; o.k = mult_kernel; o.u = mult_user; o.l = mult_last; o.c = cyc;
        got.push_back(o);
      end
      hold = mult_valid && !mult_ready;
      hd = mult_data; hu = mult_user; hl = mult_last;
    end
  end

  task automatic reset_check();
    kernel_in_valid = 1'b0; img_in_valid = 1'b0; img_in_last = 1'b0;
    aresetn = 1'b0;
    @(posedge clk); #1;
    aresetn = 1'b1;
    @(negedge clk);
    chk("rst_ctrl", {kernel_in_ready, img_in_ready, mult_valid, mult_last, err}, 0);
    chk("rst_user", mult_user, 0);
    chkw("rst_data", mult_data, '0);
    chkw("rst_kernel", mult_kernel, '0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_k_ready_rise", {kernel_in_ready, img_in_ready}, 2'b10);
    @(posedge clk); #1;
  endtask

  task automatic load_kernel(int nk, int klast);
    bit acc;
    int t;
    for (int b = 0; b < nk; b++) begin
      for (int c = 0; c < K; c++) kernel_in_data[c*M +: M] = 32'(b*K + c + 1);
      kernel_in_valid = 1'b1;
      kernel_in_last  = (b == klast);
      t = 0;
      do begin @(negedge clk); acc = kernel_in_ready; @(posedge clk); #1; t++; end
      while (!acc && t < 100);
      if (!acc) begin chk("kernel_handshake_timeout", 0, 1); break; end
    end
    kernel_in_valid = 1'b0;
    kernel_in_last  = 1'b0;
  endtask

  task automatic send_pixels(int n, int last_idx, bit gaps);
    bit acc;
    int t;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        img_in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      img_in_valid = 1'b1;
      img_in_data  = pix[i];
      img_in_last  = (i == last_idx);
      t = 0;
      do begin @(negedge clk); acc = img_in_ready; @(posedge clk); #1; t++; end
      while (!acc && t < 100);
      acc_cyc[i] = cyc;
      if (!acc) begin chk("img_handshake_timeout", 0, 1); break; end
    end
    img_in_valid = 1'b0;
    img_in_last  = 1'b0;
  endtask

  task automatic run_case(vec_t v);
    int w, nw, row, col, t;
    logic [DW-1:0] ek, d;
    got.delete();
    err_cnt = 0;
    rmode = v.rmode;
    for (int i = 0; i < v.npix; i++) pix[i] = v.rpix ? $urandom : 32'(i);
    w = (v.cfg < K) ? K : (v.cfg > WM) ? WM : v.cfg;
    ek = '0;
    for (int b = 0; b < v.nk; b++)
      for (int c = 0; c < K; c++) ek[(b*K + c)*M +: M] = 32'(b*K + c + 1);
    cfg_img_width = IB'(v.cfg);
    load_kernel(v.nk, v.klast);
    send_pixels(v.npix, v.npix - 1, v.rpix);
    t = 0;
    do begin @(negedge clk); t++; end while (!kernel_in_ready && t < 200);
    chk("back_to_load_kernel", longint'(kernel_in_ready), 1);
    chk("valid_after_drain", longint'(mult_valid), 0);
    @(posedge clk); #1;
    rmode = 0;
    chk("num_windows", got.size(), v.exp_nwin);
    chk("err_pulses", err_cnt, v.exp_err);
    if (got.size() > 0) chk("last_user", got[$].u, v.exp_lu);
    nw = 0;
    for (int i = 0; i < v.npix; i++) begin
      row = i / w;
      col = i % w;
      if (row >= K-1 && col >= K-1) begin
        for (int r = 0; r < K; r++)
          for (int c = 0; c < K; c++)
            d[(r*K + c)*M +: M] = pix[(row - K + 1 + r)*w + col - K + 1 + c];
        if (nw < got.size()) begin
          chkw("win_data", got[nw].d, d);
          chkw("win_kernel", got[nw].k, ek);
          chk("win_user", got[nw].u, {8'(row - K + 1), 8'(col - K + 1)});
          chk("win_last", longint'(got[nw].l), longint'(i == v.npix - 1));
          if (v.rmode == 0) chk("win_latency", got[nw].c, acc_cyc[i]);
        end
        nw++;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          nk klast cfg npix rmode rpix nwin err last_user
    tbl[0] = '{3,  2,    4,  16,  0,    1'b0, 4,  0, 'h0101};
    tbl[1] = '{3,  2,    4,  16,  1,    1'b0, 4,  0, 'h0101};
    tbl[2] = '{2,  1,    4,  16,  0,    1'b0, 4,  1, 'h0101};
    tbl[3] = '{3,  2,    40, 48,  0,    1'b0, 14, 1, 'h000d};
    tbl[4] = '{3,  2,    4,  8,   0,    1'b0, 0,  1, 'h0000};
    tbl[5] = '{3,  2,    2,  9,   1,    1'b0, 1,  1, 'h0000};
    tbl[6] = '{3,  -1,   5,  15,  0,    1'b0, 3,  1, 'h0002};
    tbl[7] = '{3,  2,    6,  24,  2,    1'b1, 8,  0, 'h0103};
    tbl[8] = '{3,  2,    4,  14,  1,    1'b0, 2,  1, 'h0001};
    tbl[9] = '{3,  2,    16, 48,  2,    1'b1, 14, 0, 'h000d};

    reset_check();
    for (int i = 0; i < 10; i++) run_case(tbl[i]);

    // Mid-image reset after pixel 9, then a clean rerun of the reference image.
    rmode = 0;
    cfg_img_width = 8'd4;
    for (int i = 0; i < 16; i++) pix[i] = 32'(i);
    load_kernel(3, 2);
    send_pixels(10, -1, 1'b0);
    reset_check();
    run_case(tbl[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
